// File: rtl/subtractor_serial_4bit.sv
// rtl/subtractor_serial_4bit.sv - bit-serial subtractor, LSB first, one borrow flop, start/busy/done
module subtractor_serial_4bit #(
  parameter int WIDTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_min,
  input  logic [WIDTH-1:0] i_sub,
  input  logic             i_pre_b,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_pro_b,
  output logic             o_ovf
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

  state_t             r_state;
  state_t             w_next;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic               r_br;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_min_msb;
  logic               r_sub_msb;
  logic [WIDTH-1:0]   r_diff;
  logic               r_pro_b;
  logic               r_ovf;

  logic               w_accept;
  logic               w_last;
  logic               w_d;
  logic               w_br_next;
  logic [WIDTH-1:0]   w_res_next;

  // A start is taken in IDLE and in DONE, which gives back-to-back operation.
  assign w_accept   = i_start && (r_state != S_SHIFT);
  assign w_last     = (r_state == S_SHIFT) && (r_cnt == CNT_W'(WIDTH - 1));
  assign w_d        = r_a[0] ^ r_b[0] ^ r_br;
  assign w_br_next  = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_br);
  // Difference bits enter the vacated MSB of the minuend register.
  assign w_res_next = {w_d, r_a[WIDTH-1:1]};

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_accept) w_next = S_SHIFT;
      S_SHIFT: if (w_last) w_next = S_DONE;
      S_DONE:  w_next = w_accept ? S_SHIFT : S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_br      <= 1'b0;
      r_cnt     <= '0;
      r_min_msb <= 1'b0;
      r_sub_msb <= 1'b0;
      r_diff    <= '0;
      r_pro_b   <= 1'b0;
      r_ovf     <= 1'b0;
    end else if (w_accept) begin
      r_a       <= i_min;
      r_b       <= i_sub;
      r_br      <= i_pre_b;
      r_cnt     <= '0;
      r_min_msb <= i_min[WIDTH-1];
      r_sub_msb <= i_sub[WIDTH-1];
    end else if (r_state == S_SHIFT) begin
      r_a   <= w_res_next;
      r_b   <= {1'b0, r_b[WIDTH-1:1]};
      r_br  <= w_br_next;
      r_cnt <= r_cnt + CNT_W'(1);
      if (w_last) begin
        r_diff  <= w_res_next;
        r_pro_b <= w_br_next;
        r_ovf   <= (r_min_msb != r_sub_msb) && (w_d != r_min_msb);
      end
    end
  end

  assign o_busy  = (r_state == S_SHIFT);
  assign o_done  = (r_state == S_DONE);
  assign o_diff  = r_diff;
  assign o_pro_b = r_pro_b;
  assign o_ovf   = r_ovf;

endmodule

// File: tb/tb_subtractor_serial_4bit.sv
// tb/tb_subtractor_serial_4bit.sv - scoreboard bench for subtractor_serial_4bit
module tb_subtractor_serial_4bit;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] min_v;
  logic [W-1:0] sub_v;
  logic         pre_b;
  logic         busy;
  logic         done;
  logic [W-1:0] diff;
  logic         pro_b;
  logic         ovf;

  logic [W+1:0] exp_q[$];
  logic [W+1:0] last_res = '0;
  int           vectors = 0;
  int           miscompares = 0;

  subtractor_serial_4bit #(.WIDTH(W)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_start (start),
    .i_min   (min_v),
    .i_sub   (sub_v),
    .i_pre_b (pre_b),
    .o_busy  (busy),
    .o_done  (done),
    .o_diff  (diff),
    .o_pro_b (pro_b),
    .o_ovf   (ovf)
  );

  always #5 clk = ~clk;

  // Plain integer arithmetic: {diff, borrow-out, overflow}
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic p);
    int           d;
    logic [W-1:0] dv;
    logic         borrow;
    logic         ov;
    d      = int'(a) - int'(b) - int'(p);
    dv     = d[W-1:0];
    borrow = int'(a) < (int'(b) + int'(p));
    ov     = (a[W-1] != b[W-1]) && (dv[W-1] != a[W-1]);
    return {dv, borrow, ov};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops one expectation per done pulse; otherwise outputs must hold.
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        exp_q.delete();
        last_res = '0;
      end else begin
        check("busy_done_exclusive", 32'(busy & done), 0);
        if (done) begin
          if (exp_q.size() == 0) begin
            check("spurious_done", 32'(done), 0);
          end else begin
            last_res = exp_q.pop_front();
            check("result", 32'({diff, pro_b, ovf}), 32'(last_res));
          end
        end else begin
          check("hold", 32'({diff, pro_b, ovf}), 32'(last_res));
        end
      end
    end
  end

  task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic p);
    int n = 0;
    while (busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout_busy", 32'(busy), 0);
    min_v = a;
    sub_v = b;
    pre_b = p;
    start = 1'b1;
    exp_q.push_back(model(a, b, p));
    @(posedge clk);
    #1;
    start = 1'b0;
    min_v = W'($urandom_range(0, 15));
    sub_v = W'($urandom_range(0, 15));
    pre_b = 1'($urandom_range(0, 1));
    @(negedge clk);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || done) && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) check("timeout_idle", 32'(busy | done), 0);
  endtask

  task automatic ignored_start();
    min_v = W'($urandom_range(0, 15));
    sub_v = W'($urandom_range(0, 15));
    pre_b = 1'($urandom_range(0, 1));
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int n;
    rst   = 1'b1;
    start = 1'b0;
    min_v = '0;
    sub_v = '0;
    pre_b = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_busy", 32'(busy), 0);
    check("reset_done", 32'(done), 0);
    check("reset_result", 32'({diff, pro_b, ovf}), 0);
    rst = 1'b0;
    @(negedge clk);

    // Latency: WIDTH busy cycles, then the done pulse.
    do_op(4'd9, 4'd3, 1'b0);
    n = 0;
    while (busy && n < 20) begin
      n++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(n), W);
    check("done_after_busy", 32'(done), 1);
    wait_idle();

    do_op(4'd3, 4'd9, 1'b0);  wait_idle();
    do_op(4'd0, 4'd0, 1'b1);  wait_idle();
    do_op(4'd8, 4'd1, 1'b0);  wait_idle();
    do_op(4'd6, 4'd15, 1'b1); wait_idle();
    do_op(4'd15, 4'd15, 1'b1); wait_idle();

    // Start during SHIFT is ignored; start in the DONE cycle is taken.
    do_op(4'd9, 4'd3, 1'b0);
    ignored_start();
    do_op(4'd5, 4'd2, 1'b0);
    wait_idle();

    // Asynchronous reset mid-operation, then a clean operation.
    do_op(4'd0, 4'd5, 1'b1);
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst_busy", 32'(busy), 0);
    check("async_rst_done", 32'(done), 0);
    check("async_rst_result", 32'({diff, pro_b, ovf}), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    do_op(4'd7, 4'd7, 1'b0);
    wait_idle();

    for (int i = 0; i < 60; i++) begin
      do_op(W'($urandom_range(0, 15)), W'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) ignored_start();
      if ($urandom_range(0, 2) == 0) wait_idle();
    end

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("drain_queue", 32'(exp_q.size()), 0);
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
